// File: rtl/attopu_pkg.sv
// Shared encodings for the attopu execute stage: opcodes, FSM states and fixed field widths.
package attopu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned DST_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: WIDTH iterations, the first taken on the start edge.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             running;

  // done pulses for one cycle once the WIDTH-th partial product is accumulated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? PW'(a) : '0;
        mcand   <= PW'(a) << 1;
        mplier  <= b >> 1;
        cnt     <= CW'(1);
        running <= 1'b1;
      end else if (running) begin
        product <= product + (mplier[0] ? mcand : '0);
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        cnt     <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative MUL, with registered write-back and flags.
module exec_stage
  import attopu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [DST_W-1:0] dst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] wb_data,
  output logic [DST_W-1:0] wb_sel,
  output logic             wb_en,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  state_e           state;
  logic [DST_W-1:0] dst_q;
  logic             fire_c;
  logic             start_c;
  logic             mul_done;
  logic [PW-1:0]    mul_product;

  logic [WIDTH:0]   add_c, sub_c, shl_c, shr_c;
  logic [SW-1:0]    shamt_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;

  assign fire_c  = issue_valid && issue_ready;
  assign start_c = fire_c && (op_e'(op) == OP_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start_c),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle ALU; shifts run one bit wide so the last bit out lands at the edge
  always_comb begin
    add_c   = {1'b0, a} + {1'b0, b};
    sub_c   = {1'b0, a} - {1'b0, b};
    shamt_c = b[SW-1:0];
    shl_c   = {1'b0, a} << shamt_c;
    shr_c   = {a, 1'b0} >> shamt_c;
    res_c   = '0;
    carry_c = 1'b0;
    case (op_e'(op))
      OP_ADD: begin res_c = add_c[WIDTH-1:0]; carry_c = add_c[WIDTH]; end
      OP_SUB: begin res_c = sub_c[WIDTH-1:0]; carry_c = sub_c[WIDTH]; end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_SHL: begin res_c = shl_c[WIDTH-1:0]; carry_c = shl_c[WIDTH]; end
      OP_SHR: begin res_c = shr_c[WIDTH:1];   carry_c = shr_c[0];     end
      default: begin res_c = '0; carry_c = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      issue_ready <= 1'b1;
      busy        <= 1'b0;
      wb_en       <= 1'b0;
      wb_data     <= '0;
      wb_sel      <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      dst_q       <= '0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        ST_IDLE, ST_WB: begin
          if (fire_c) begin
            if (start_c) begin
              state       <= ST_MUL;
              busy        <= 1'b1;
              issue_ready <= 1'b0;
              dst_q       <= dst;
            end else begin
              state   <= ST_WB;
              wb_en   <= 1'b1;
              wb_data <= res_c;
              wb_sel  <= dst;
              flag_z  <= (res_c == '0);
              flag_c  <= carry_c;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state       <= ST_WB;
            busy        <= 1'b0;
            issue_ready <= 1'b1;
            wb_en       <= 1'b1;
            wb_data     <= mul_product[WIDTH-1:0];
            wb_sel      <= dst_q;
            flag_z      <= (mul_product[WIDTH-1:0] == '0);
            flag_c      <= |mul_product[PW-1:WIDTH];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed corner cases plus randomized ops against an arithmetic model.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  op = '0;
  logic [1:0]  dst = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] wb_data;
  logic [1:0]  wb_sel;
  logic        wb_en;
  logic        busy;
  logic        flag_z;
  logic        flag_c;

  int checks = 0;
  int errors = 0;

  exec_stage #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .op          (op),
    .dst         (dst),
    .a           (a),
    .b           (b),
    .wb_data     (wb_data),
    .wb_sel      (wb_sel),
    .wb_en       (wb_en),
    .busy        (busy),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the opcode definitions
  function automatic void model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic c);
    longint t;
    int s;
    s = int'(y) % 16;
    c = 1'b0;
    case (o)
      3'd0: begin t = longint'(x) + longint'(y); r = 16'(t % 65536); c = (t >= 65536); end
      3'd1: begin t = longint'(x) - longint'(y); if (t < 0) t = t + 65536; r = 16'(t); c = (x < y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        t = (longint'(x) * (longint'(1) << s)) % 65536; r = 16'(t);
        c = (s != 0) ? 1'((longint'(x) / (longint'(1) << (16 - s))) % 2) : 1'b0;
      end
      3'd6: begin
        r = 16'(longint'(x) / (longint'(1) << s));
        c = (s != 0) ? 1'((longint'(x) / (longint'(1) << (s - 1))) % 2) : 1'b0;
      end
      default: begin t = longint'(x) * longint'(y); r = 16'(t % 65536); c = (t / 65536) != 0; end
    endcase
  endfunction

  // Offer one op at a negedge; returns #1 after the handshake edge
  task automatic issue_op(input logic [2:0] o, input logic [1:0] d, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    op = o; dst = d; a = x; b = y; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({wb_en, busy, flag_z, flag_c} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: got en/busy/z/c=%b expected 0000", {wb_en, busy, flag_z, flag_c});
    end
    checks++;
    if (wb_data !== 16'h0 || wb_sel !== 2'd0) begin
      errors++; $display("FAIL reset_data: got data=%h sel=%0d expected 0000/0", wb_data, wb_sel);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", issue_ready);
    end
  endtask

  task automatic test_directed;
    issue_op(3'd0, 2'd2, 16'hFFFF, 16'h0001);
    checks++;
    if ({wb_en, wb_data, wb_sel, flag_z, flag_c} !== {1'b1, 16'h0000, 2'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL add_wrap: got en=%b d=%h s=%0d z=%b c=%b expected 1 0000 2 1 1",
                         wb_en, wb_data, wb_sel, flag_z, flag_c);
    end
    issue_op(3'd1, 2'd1, 16'd3, 16'd5);
    checks++;
    if ({wb_en, wb_data, flag_z, flag_c} !== {1'b1, 16'hFFFE, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sub_borrow: got en=%b d=%h z=%b c=%b expected 1 fffe 0 1", wb_en, wb_data, flag_z, flag_c);
    end
    issue_op(3'd5, 2'd3, 16'h8001, 16'd1);
    checks++;
    if ({wb_en, wb_data, flag_c} !== {1'b1, 16'h0002, 1'b1}) begin
      errors++; $display("FAIL shl_carry: got en=%b d=%h c=%b expected 1 0002 1", wb_en, wb_data, flag_c);
    end
    issue_op(3'd6, 2'd0, 16'h8001, 16'd0);
    checks++;
    if ({wb_data, flag_c, flag_z} !== {16'h8001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL shr_zero_amt: got d=%h c=%b z=%b expected 8001 0 0", wb_data, flag_c, flag_z);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_en !== 1'b0 || wb_data !== 16'h8001 || flag_c !== 1'b0) begin
      errors++; $display("FAIL hold_after_wb: got en=%b d=%h c=%b expected 0 8001 0", wb_en, wb_data, flag_c);
    end
  endtask

  task automatic test_mul;
    issue_op(3'd7, 2'd1, 16'd300, 16'd300);
    // offer an ADD while MUL iterates; it must be ignored
    op = 3'd0; dst = 2'd3; a = 16'd7; b = 16'd7; issue_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (busy !== 1'b1 || issue_ready !== 1'b0 || wb_en !== 1'b0) begin
        errors++; $display("FAIL mul_busy_c%0d: got busy=%b ready=%b en=%b expected 1 0 0", k, busy, issue_ready, wb_en);
      end
      if (k == 16) issue_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if ({wb_en, busy, issue_ready, wb_data, wb_sel, flag_c, flag_z} !== {1'b1, 1'b0, 1'b1, 16'h5F90, 2'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mul_wb: got en=%b busy=%b rdy=%b d=%h s=%0d c=%b z=%b expected 1 0 1 5f90 1 1 0",
                         wb_en, busy, issue_ready, wb_data, wb_sel, flag_c, flag_z);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_en !== 1'b0 || wb_data !== 16'h5F90) begin
      errors++; $display("FAIL mul_no_extra: got en=%b d=%h expected 0 5f90", wb_en, wb_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] x [3];
    logic [15:0] y [3];
    logic [2:0]  o [3];
    logic [15:0] er;
    logic        ec;
    o[0] = 3'd4; o[1] = 3'd3; o[2] = 3'd2;
    for (int i = 0; i < 3; i++) begin x[i] = 16'($urandom); y[i] = 16'($urandom); end
    @(negedge clk);
    op = o[0]; dst = 2'd0; a = x[0]; b = y[0]; issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      model(o[i], x[i], y[i], er, ec);
      checks++;
      if (wb_en !== 1'b1 || wb_data !== er || wb_sel !== 2'(i) || flag_c !== ec) begin
        errors++; $display("FAIL b2b_%0d: got en=%b d=%h s=%0d c=%b expected 1 %h %0d %b", i, wb_en, wb_data, wb_sel, flag_c, er, i, ec);
      end
      if (i < 2) begin op = o[i+1]; dst = 2'(i + 1); a = x[i+1]; b = y[i+1]; end
      else issue_valid = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (wb_en !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got en=%b expected 0", wb_en);
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [1:0]  d;
    logic [15:0] x, y, er;
    logic        ec;
    int          lat, expl;
    for (int n = 0; n < 80; n++) begin
      o = 3'($urandom_range(0, 7));
      d = 2'($urandom);
      x = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 5) == 0) y[3:0] = 4'd0;
      model(o, x, y, er, ec);
      expl = (o == 3'd7) ? 17 : 1;
      issue_op(o, d, x, y);
      lat = 1;
      while (wb_en !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++;
      if (wb_en !== 1'b1 || lat != expl) begin
        errors++; $display("FAIL rand_lat_%0d: got en=%b lat=%0d expected 1 %0d", n, wb_en, lat, expl);
      end
      checks++;
      if (wb_data !== er || wb_sel !== d || flag_c !== ec || flag_z !== (er == 16'h0)) begin
        errors++; $display("FAIL rand_res_%0d op=%0d a=%h b=%h: got d=%h s=%0d c=%b z=%b expected %h %0d %b %b",
                           n, o, x, y, wb_data, wb_sel, flag_c, flag_z, er, d, ec, (er == 16'h0));
      end
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_mul;
    int stray;
    issue_op(3'd7, 2'd2, 16'h1234, 16'h0567);
    repeat (7) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_mul_busy: got %b expected 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_en, busy, flag_z, flag_c, wb_data, wb_sel, issue_ready} !== {4'b0000, 16'h0000, 2'd0, 1'b1}) begin
      errors++; $display("FAIL mid_mul_reset: got en=%b busy=%b z=%b c=%b d=%h s=%0d rdy=%b expected 0 0 0 0 0000 0 1",
                         wb_en, busy, flag_z, flag_c, wb_data, wb_sel, issue_ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (wb_en !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL abort_no_wb: got %0d bad cycles expected 0", stray);
    end
    issue_op(3'd0, 2'd3, 16'd1, 16'd1);
    checks++;
    if ({wb_en, wb_data, wb_sel, flag_z, flag_c} !== {1'b1, 16'd2, 2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL post_reset_add: got en=%b d=%h s=%0d z=%b c=%b expected 1 0002 3 0 0",
                         wb_en, wb_data, wb_sel, flag_z, flag_c);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
